// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM states, latency ceiling, byte-enable legality.
package dmem_responder_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_resp_state_t;

   localparam int DMEM_MAX_LATENCY = 15;

   // RV32I stores only ever produce a single byte, an aligned halfword or a full word.
   function automatic logic mbe_legal(input logic [3:0] mbe);
      case (mbe)
         4'b0001, 4'b0010, 4'b0100, 4'b1000,
         4'b0011, 4'b1100, 4'b1111: mbe_legal = 1'b1;
         default:                   mbe_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_responder_mbe_merge.sv
// Combinational byte-lane merge: each lane with mbe[i]=1 takes wdata, others keep old_word.
module mbe_merge (
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   input  logic [3:0]  mbe,
   output logic [31:0] merged
);

   always_comb begin
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (mbe[i]) merged[8*i +: 8] = wdata[8*i +: 8];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder; answers LATENCY cycles after acceptance with a one-cycle resp.
// Optional DMEM_RESP_ERR_EN adds dmem_err for out-of-range accesses and illegal byte enables.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dmem_read,
   input  logic        dmem_write,
   input  logic [31:0] dmem_address,
   input  logic [31:0] dmem_wdata,
   input  logic [3:0]  dmem_mbe,
   output logic [31:0] dmem_rdata,
   output logic        dmem_resp
`ifdef DMEM_RESP_ERR_EN
   ,
   output logic        dmem_err
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   if (LATENCY < 1 || LATENCY > DMEM_MAX_LATENCY) begin : g_bad_latency
      $fatal(1, "dmem_responder: LATENCY must be 1..15");
   end
   if ((1 << AW) != DEPTH) begin : g_bad_depth
      $fatal(1, "dmem_responder: DEPTH must be a power of two");
   end

   dmem_resp_state_t state, state_nxt;
   logic [3:0]       count;
   logic [31:2]      addr_q;
   logic [31:0]      wdata_q;
   logic [3:0]       mbe_q;
   logic             is_write_q;

   logic [31:0]      mem [DEPTH];
   logic [AW-1:0]    idx;
   logic             in_range;
   logic             bad;
   logic [31:0]      merged;
   logic             unused_addr_lsb;

   assign unused_addr_lsb = ^dmem_address[1:0];
   assign idx      = addr_q[AW+1:2];
   assign in_range = (addr_q >> AW) == '0;

`ifdef DMEM_RESP_ERR_EN
   assign bad      = !in_range || !mbe_legal(mbe_q);
   assign dmem_err = (state == RESP) && bad;
`else
   assign bad      = !in_range;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (dmem_read || dmem_write) state_nxt = (LATENCY == 1) ? RESP : WAIT;
         WAIT:    if (count == 4'd1) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         count      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         mbe_q      <= '0;
         is_write_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && (dmem_read || dmem_write)) begin
            addr_q     <= dmem_address[31:2];
            wdata_q    <= dmem_wdata;
            mbe_q      <= dmem_mbe;
            is_write_q <= dmem_write;
            count      <= LAT_M1;
         end else if (state == WAIT) begin
            count <= count - 4'd1;
         end
      end
   end

   mbe_merge u_merge (
      .old_word (mem[idx]),
      .wdata    (wdata_q),
      .mbe      (mbe_q),
      .merged   (merged)
   );

   // Array is deliberately not reset; the rst term only blocks a commit while reset is held.
   always_ff @(posedge clk) begin
      if (rst && state == RESP && is_write_q && !bad) mem[idx] <= merged;
   end

   // The array holds its value through RESP, so read data is stable for the whole pulse.
   assign dmem_resp  = (state == RESP);
   assign dmem_rdata = (state == RESP && !is_write_q && !bad) ? mem[idx] : 32'h0;

endmodule
